servo_pwm_decoder: RTL and testbench
====================================

# servo_pwm_decoder

Receive-side counterpart to the servo PWM generator path. Measures the high time and period of an incoming 50 Hz hobby-servo PWM signal, from an RC receiver or a looped-back GPIO pin. Converts the high time back into an 8-bit angle (0–180) using the same linear mapping the generator uses. Sits between a GPIO input and the gait/control logic, and flags lost or malformed signals.

## Interface
Parameters:
- FRAME_CLKS, 1_000_000: nominal frame length in clocks (20 ms at 50 MHz).
- MIN_CLKS, 25_000: high time for angle 0 (0.5 ms).
- MAX_CLKS, 125_000: high time for angle 180 (2.5 ms).
- TOL_CLKS, 2_500: accepted slack outside [MIN_CLKS, MAX_CLKS] (50 µs).
- TIMEOUT_CLKS, 2_000_000: clocks without a rising edge before `lost` is asserted.

Ports:
- clk, in, 1: system clock (FPGA_CLK1_50). One clock domain only.
- reset, in, 1: reset. Synchronous, active-high.
- pwm_in, in, 1: asynchronous PWM input.
- angle, out, 8: last decoded angle, 0..180.
- angle_valid, out, 1: one-cycle pulse when `angle` is updated.
- width, out, 32: last accepted high time, in clocks.
- period, out, 32: last rising-to-rising interval, in clocks.
- range_err, out, 1: one-cycle pulse when a high time falls outside the tolerance window.
- lost, out, 1: level; no valid signal present.

## Operation
- Input path: 2-FF synchronizer, then a third register for edge detect. `rise` = s2 & ~s3; `fall` = ~s2 & s3.
- Measurement FSM:
  - IDLE: wait for `rise`; clear hi_cnt and per_cnt; go to HIGH.
  - HIGH: hi_cnt++ and per_cnt++ each cycle. On `fall`, evaluate the width and go to LOW.
  - LOW: per_cnt++. On `rise`, load `period` <= per_cnt + 1, clear both counters, go to HIGH.
  - Timeout: in any state other than IDLE, per_cnt reaching TIMEOUT_CLKS sets `lost`=1 and forces IDLE. IDLE itself never times out.
- Counters are 32-bit and saturate at all-ones; they never wrap.
- Width evaluation on `fall` (w = hi_cnt + 1):
  - w < MIN_CLKS-TOL_CLKS or w > MAX_CLKS+TOL_CLKS: pulse `range_err`. `width`, `angle` and `lost` are unchanged.
  - Otherwise: load `width` <= w and start the converter with w clamped to [MIN_CLKS, MAX_CLKS].
- Converter:
  - STEP = (MAX_CLKS-MIN_CLKS)/180 (integer division; 555 by default), identical to the generator.
  - Computes angle = floor((wc - MIN_CLKS + STEP/2) / STEP), clamped to 180.
  - Implemented as repeated subtraction: r starts at wc - MIN_CLKS + STEP/2, q at 0. Each cycle, while r >= STEP and q < 180: r -= STEP, q++.
  - When done: load `angle` <= q, pulse `angle_valid`, clear `lost`.
- Converter busy when a new accepted width arrives: the new width is dropped. This cannot happen for legal frames, since low time ≥ 17.5 ms ≫ 181 cycles.
- `period` is first updated on the second rising edge after leaving IDLE.

## Timing
- Reset values: angle=0, angle_valid=0, width=0, period=0, range_err=0, lost=1; FSM=IDLE; converter idle; synchronizer regs=0.
- A pwm_in rising transition does not itself count as a `rise` out of reset; a `rise` requires s3=0 first, which reset guarantees.
- Let N be the first clk edge that samples pwm_in low after a high pulse.
  - `fall` is seen at N+2.
  - `width` and `range_err` update at N+3.
  - `angle`/`angle_valid` at N+4+q, where q is the decoded angle. Worst case N+184.
- A width of exactly MIN_CLKS+STEP*a decodes to a, for every a in 0..180.
- Reset asserted mid-pulse or mid-conversion: all state returns to reset values on the next edge, with no partial output.
- `rise` and timeout in the same cycle: `rise` wins and the counters restart.
- Timeout is measured from the last rising edge: a stuck-high or stuck-low input asserts `lost` TIMEOUT_CLKS cycles after that edge.

## Structure
- Shared package servo_pkg holds DUR_CLOCK_NUM (1_000_000), DEGREE_MIN (25_000), DEGREE_MAX (125_000), ANGLE_MAX (180) and DEGREE_STEP (555). The generator and this decoder both take their defaults from it.
- One sub-module, servo_width_to_angle: the sequential subtract-and-count converter with start/done handshake. Ports: clk, reset, start, width_in[31:0], busy, done, angle_out[7:0].
- The measurement FSM and synchronizer stay in the top.

## Test plan
- Generator loopback at angles 0, 90 and 180 (widths 25_000, 74_950, 124_900), 20 ms frames -> `angle` = 0, 90, 180. `angle_valid` pulses once per frame, at N+4, N+94, N+184. `period` = 1_000_000.
- Sweep angle 0..180 in loopback -> decoded angle equals the commanded angle for every value.
- Width 23_000 -> angle 0. Width 127_000 -> angle 180. Width 20_000 -> `range_err` pulse, `angle` unchanged.
- Input held low after three good frames -> `lost` rises exactly 2_000_000 cycles after the last rising edge. The next good frame clears `lost` at its `angle_valid`.
- Reset pulse mid-high-pulse -> outputs at reset values, `lost`=1. The partial pulse is ignored; the first full pulse after reset decodes correctly.
- Glitch of 3 high cycles inside the low phase -> `range_err` pulse. `period` reports the shortened interval; `angle` is unchanged.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing constants used by both the PWM generator and the
// decoder, plus the decoder's measurement-state encoding.
package servo_pkg;

    localparam int unsigned DUR_CLOCK_NUM = 1_000_000;  // 20 ms frame at 50 MHz
    localparam int unsigned DEGREE_MIN    = 25_000;     // 0.5 ms -> 0 degrees
    localparam int unsigned DEGREE_MAX    = 125_000;    // 2.5 ms -> 180 degrees
    localparam int unsigned ANGLE_MAX     = 180;
    localparam int unsigned DEGREE_STEP   = (DEGREE_MAX - DEGREE_MIN) / ANGLE_MAX;

    typedef enum logic [1:0] {
        MEAS_IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } meas_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/servo_width_to_angle.sv
// Sequential width-to-angle converter: subtracts STEP until the remainder
// drops below one step (or the angle saturates), counting the subtractions.
// width_in must already be clamped to [MIN_CLKS, MAX_CLKS].
// Handshake: start is accepted only while busy is low; done pulses for one
// cycle with angle_out already holding the new result.
module servo_width_to_angle
    import servo_pkg::*;
#(
    parameter int unsigned MIN_CLKS = DEGREE_MIN,
    parameter int unsigned MAX_CLKS = DEGREE_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] width_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  angle_out
);

    localparam logic [31:0] STEP_W = 32'((MAX_CLKS - MIN_CLKS) / ANGLE_MAX);
    localparam logic [31:0] MIN_W  = 32'(MIN_CLKS);
    localparam logic [31:0] HALF_W = STEP_W >> 1;
    localparam logic [7:0]  QMAX   = 8'(ANGLE_MAX);

    logic [31:0] rem;
    logic [7:0]  quo;

    // Load on start, then one subtraction per cycle until finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rem       <= 32'd0;
            quo       <= 8'd0;
            angle_out <= 8'd0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    rem  <= width_in - MIN_W + HALF_W;
                    quo  <= 8'd0;
                    busy <= 1'b1;
                end
            end else if (rem >= STEP_W && quo < QMAX) begin
                rem <= rem - STEP_W;
                quo <= quo + 8'd1;
            end else begin
                angle_out <= quo;
                done      <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: synchronizes pwm_in, measures high time and period,
// rejects widths outside the tolerance window, converts accepted widths to
// an angle and flags a lost signal when rising edges stop arriving.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CLKS   = DUR_CLOCK_NUM,
    parameter int unsigned MIN_CLKS     = DEGREE_MIN,
    parameter int unsigned MAX_CLKS     = DEGREE_MAX,
    parameter int unsigned TOL_CLKS     = 2_500,
    parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [7:0]  angle,
    output logic        angle_valid,
    output logic [31:0] width,
    output logic [31:0] period,
    output logic        range_err,
    output logic        lost
);

    localparam logic [31:0] MIN_W = 32'(MIN_CLKS);
    localparam logic [31:0] MAX_W = 32'(MAX_CLKS);
    localparam logic [31:0] LO_W  = (MIN_CLKS > TOL_CLKS) ? 32'(MIN_CLKS - TOL_CLKS) : 32'd0;
    localparam logic [31:0] HI_W  = 32'(MAX_CLKS + TOL_CLKS);
    // A timeout shorter than one frame would flag every healthy signal as
    // lost, so fall back to two frames if misconfigured.
    localparam logic [31:0] TMO_W =
        32'((TIMEOUT_CLKS > FRAME_CLKS) ? TIMEOUT_CLKS : 2 * FRAME_CLKS);
    localparam logic [31:0] TMO_LAST = TMO_W - 32'd1;

    logic        s1, s2, s3;
    logic        rise, fall;
    meas_state_t state, state_n;
    logic [31:0] hi_cnt, hi_n, per_cnt, per_n, period_n;
    logic [31:0] w_eval, w_n;
    logic        eval_pend, eval_n;
    logic        lost_r, lost_set, timeout;
    logic        out_of_range;
    logic [31:0] w_clamped;
    logic        conv_start, conv_busy, conv_done;
    logic [7:0]  conv_angle;

    // Two-flop synchronizer plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    // Asserted when per_cnt is about to reach the timeout value.
    assign timeout = (state != MEAS_IDLE) && (per_cnt >= TMO_LAST);

    // Measurement FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MEAS_IDLE;
            hi_cnt    <= 32'd0;
            per_cnt   <= 32'd0;
            period    <= 32'd0;
            w_eval    <= 32'd0;
            eval_pend <= 1'b0;
        end else begin
            state     <= state_n;
            hi_cnt    <= hi_n;
            per_cnt   <= per_n;
            period    <= period_n;
            w_eval    <= w_n;
            eval_pend <= eval_n;
        end
    end

    // Measurement FSM next-state: counts high/period, requests width evaluation on fall.
    always_comb begin
        state_n  = state;
        hi_n     = hi_cnt;
        per_n    = per_cnt;
        period_n = period;
        w_n      = w_eval;
        eval_n   = 1'b0;
        lost_set = 1'b0;
        case (state)
            MEAS_IDLE: begin
                if (rise) begin
                    hi_n    = 32'd0;
                    per_n   = 32'd0;
                    state_n = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                hi_n  = sat_inc(hi_cnt);
                per_n = sat_inc(per_cnt);
                if (fall) begin
                    w_n     = sat_inc(hi_cnt);
                    eval_n  = 1'b1;
                    state_n = MEAS_LOW;
                end
            end
            MEAS_LOW: begin
                per_n = sat_inc(per_cnt);
                if (rise) begin
                    period_n = sat_inc(per_cnt);
                    hi_n     = 32'd0;
                    per_n    = 32'd0;
                    state_n  = MEAS_HIGH;
                end
            end
            default: state_n = MEAS_IDLE;
        endcase
        // A rise in the same cycle restarts the counters instead.
        if (timeout && !rise) begin
            state_n  = MEAS_IDLE;
            eval_n   = 1'b0;
            lost_set = 1'b1;
        end
    end

    assign out_of_range = (w_eval < LO_W) || (w_eval > HI_W);
    assign w_clamped    = (w_eval < MIN_W) ? MIN_W : ((w_eval > MAX_W) ? MAX_W : w_eval);
    // A width arriving while the converter is still busy is dropped.
    assign conv_start   = eval_pend & ~out_of_range & ~conv_busy;

    // Evaluation stage: publish accepted width or flag an out-of-window pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            width     <= 32'd0;
            range_err <= 1'b0;
        end else begin
            range_err <= 1'b0;
            if (eval_pend) begin
                if (out_of_range) begin
                    range_err <= 1'b1;
                end else begin
                    width <= w_eval;
                end
            end
        end
    end

    // Lost flag: set by timeout, cleared by a completed conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            lost_r <= 1'b1;
        end else if (lost_set) begin
            lost_r <= 1'b1;
        end else if (conv_done) begin
            lost_r <= 1'b0;
        end
    end

    servo_width_to_angle #(
        .MIN_CLKS (MIN_CLKS),
        .MAX_CLKS (MAX_CLKS)
    ) u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (conv_start),
        .width_in  (w_clamped),
        .busy      (conv_busy),
        .done      (conv_done),
        .angle_out (conv_angle)
    );

    assign angle       = conv_angle;
    assign angle_valid = conv_done;
    // lost already reads low in the cycle the new angle is presented.
    assign lost        = lost_r & ~conv_done;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with scaled-down timing parameters.
// Drivers push expected results into queues; a monitor pops and compares
// whenever angle_valid or range_err fires.
module tb_servo_pwm_decoder;

    localparam int MIN   = 100;
    localparam int MAX   = 1000;   // STEP = 900/180 = 5
    localparam int TOL   = 20;     // accepted window 80..1020
    localparam int FRAME = 1500;
    localparam int TMO   = 4000;
    localparam int STEP  = (MAX - MIN) / 180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [7:0]  angle;
    logic        angle_valid;
    logic [31:0] width;
    logic [31:0] period;
    logic        range_err;
    logic        lost;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // {angle[7:0], width[31:0], cycle[31:0]}
    logic [71:0] exp_q[$];
    logic [71:0] err_q[$];
    logic [71:0] mon_e;
    logic [7:0]  model_angle = 8'd0;
    logic [31:0] model_width = 32'd0;

    servo_pwm_decoder #(
        .FRAME_CLKS   (FRAME),
        .MIN_CLKS     (MIN),
        .MAX_CLKS     (MAX),
        .TOL_CLKS     (TOL),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .angle       (angle),
        .angle_valid (angle_valid),
        .width       (width),
        .period      (period),
        .range_err   (range_err),
        .lost        (lost)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && angle_valid) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("angle", angle, mon_e[71:64]);
                chk("width_at_valid", width, mon_e[63:32]);
                chk("valid_cycle", cyc, mon_e[31:0]);
                chk("lost_at_valid", lost, 0);
            end
        end
        if (!reset && range_err) begin
            if (err_q.size() == 0) begin
                chk("range_err_unexpected", 1, 0);
            end else begin
                mon_e = err_q.pop_front();
                chk("angle_kept", angle, mon_e[71:64]);
                chk("width_kept", width, mon_e[63:32]);
                chk("range_err_cycle", cyc, mon_e[31:0]);
            end
        end
    end

    // One high pulse of w cycles followed by low cycles; pushes the expected outcome.
    task automatic pulse(input int w, input int low, output int k);
        int n, wc, q;
        @(posedge clk);
        #1;
        k = cyc;
        pwm_in = 1'b1;
        repeat (w) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        n = k + w + 1;  // first edge that samples low
        if (w < MIN - TOL || w > MAX + TOL) begin
            err_q.push_back({model_angle, model_width, 32'(n + 3)});
        end else begin
            wc = (w < MIN) ? MIN : ((w > MAX) ? MAX : w);
            q = (wc - MIN + STEP / 2) / STEP;
            if (q > 180) q = 180;
            model_angle = 8'(q);
            model_width = 32'(w);
            exp_q.push_back({model_angle, model_width, 32'(n + 4 + q)});
        end
        repeat (low - 1) @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_angle"}, angle, 0);
        chk({tag, "_valid"}, angle_valid, 0);
        chk({tag, "_width"}, width, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_range_err"}, range_err, 0);
        chk({tag, "_lost"}, lost, 1);
    endtask

    // p = first edge sampling pwm_in high; lost must rise at edge p+2+TMO.
    task automatic check_lost_rise(input int p, input string tag);
        int target;
        target = p + 2 + TMO;
        #1;
        while (cyc < target - 1) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_lost_before"}, lost, 0);
        @(posedge clk);
        #1;
        chk({tag, "_lost_at"}, lost, 1);
    endtask

    int k;
    int widths[18] = '{102, 103, 125, 145, 325, 545, 552, 553, 555, 995,
                       90, 1010, 80, 1020, 79, 1021, 70, 1000};

    initial begin
        // Reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Angles 0, 90, 180 with full frames
        pulse(100, FRAME - 100, k);
        chk("lost_after_first", lost, 0);
        pulse(550, FRAME - 550, k);
        chk("period_frame2", period, FRAME);
        pulse(1000, FRAME - 1000, k);
        chk("period_frame3", period, FRAME);

        // Grid points, rounding, clamping, window edges, rejections
        foreach (widths[i]) pulse(widths[i], FRAME - widths[i], k);

        // Glitch inside the low phase
        pulse(550, 400, k);
        pulse(3, FRAME - 550 - 400 - 3, k);
        chk("period_glitch", period, 950);
        pulse(550, FRAME - 550, k);
        chk("period_after_glitch", period, 550);

        // Input held low after good frames
        pulse(325, FRAME - 325, k);
        check_lost_rise(k + 1, "stuck_low");
        pulse(325, FRAME - 325, k);
        chk("lost_recovered", lost, 0);

        // Input stuck high
        @(posedge clk);
        #1;
        k = cyc;
        pwm_in = 1'b1;
        check_lost_rise(k + 1, "stuck_high");
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        pulse(545, FRAME - 545, k);

        // Reset in the middle of a high pulse, held until the pulse ends
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("reset_mid_pulse");
        model_angle = 8'd0;
        model_width = 32'd0;
        reset = 1'b0;
        pulse(325, FRAME - 325, k);
        chk("period_after_reset", period, 0);

        // Reset in the middle of a long conversion
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset_mid_conv");
        model_angle = 8'd0;
        model_width = 32'd0;
        reset = 1'b0;
        repeat (300) @(posedge clk);
        pulse(995, FRAME - 995, k);

        repeat (300) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
